// File: rtl/multiport_register_file.sv
`default_nettype none
// multiport_register_file: two combinational read ports and one write port with write-first bypass,
// plus a one-register-per-cycle clear sweep (IDLE -> CLEAR -> DONE). Rev 1.0
module multiport_register_file #(
  parameter int DATA_WIDTH = 8,
  parameter int NUM_REGS   = 8,
  parameter int ADDR_WIDTH = $clog2(NUM_REGS),
  parameter int OUT_REG    = NUM_REGS - 1
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  wr_en,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic [ADDR_WIDTH-1:0] rd_addr_a,
  input  logic [ADDR_WIDTH-1:0] rd_addr_b,
  output logic [DATA_WIDTH-1:0] rd_data_a,
  output logic [DATA_WIDTH-1:0] rd_data_b,
  input  logic                  clear_req,
  output logic                  clear_busy,
  output logic                  clear_done,
  output logic                  wr_err,
  output logic [DATA_WIDTH-1:0] output_reg_val
);

  localparam logic [ADDR_WIDTH:0] C_NUM_REGS = (ADDR_WIDTH+1)'(NUM_REGS);
  localparam logic [ADDR_WIDTH:0] C_LAST_IDX = (ADDR_WIDTH+1)'(NUM_REGS - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CLEAR = 2'd1,
    DONE  = 2'd2
  } state_e;

  state_e                state_q, state_d;
  logic [ADDR_WIDTH:0]   cnt_q, cnt_d;
  logic                  wr_err_q, wr_err_d;
  logic [DATA_WIDTH-1:0] regs_q [NUM_REGS];
  logic                  w_wr_ok;

  assign w_wr_ok  = wr_en && ({1'b0, wr_addr} < C_NUM_REGS) && (state_q != CLEAR);
  assign wr_err_d = wr_en && !w_wr_ok;

  // Bypass only on accepted writes; out-of-range reads return zero.
  assign rd_data_a = (w_wr_ok && (rd_addr_a == wr_addr)) ? wr_data :
                     ({1'b0, rd_addr_a} < C_NUM_REGS) ? regs_q[rd_addr_a] : '0;
  assign rd_data_b = (w_wr_ok && (rd_addr_b == wr_addr)) ? wr_data :
                     ({1'b0, rd_addr_b} < C_NUM_REGS) ? regs_q[rd_addr_b] : '0;

  assign output_reg_val = regs_q[OUT_REG];
  assign clear_busy     = (state_q == CLEAR);
  assign clear_done     = (state_q == DONE);
  assign wr_err         = wr_err_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (clear_req) begin
          state_d = CLEAR;
          cnt_d   = '0;
        end
      end
      CLEAR: begin
        cnt_d = cnt_q + (ADDR_WIDTH+1)'(1);
        if (cnt_q == C_LAST_IDX) begin
          state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      wr_err_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      wr_err_q <= wr_err_d;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs_q[i] <= '0;
      end
    end else if (state_q == CLEAR) begin
      regs_q[cnt_q[ADDR_WIDTH-1:0]] <= '0;
    end else if (w_wr_ok) begin
      regs_q[wr_addr] <= wr_data;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_multiport_register_file.sv
`default_nettype none
// Directed self-checking bench for multiport_register_file (8-entry and 6-entry instances).
module tb_multiport_register_file;

  logic       clock, reset_n;
  logic       wr_en, clear_req;
  logic [2:0] wr_addr, rd_addr_a, rd_addr_b;
  logic [7:0] wr_data;
  logic [7:0] rd_data_a, rd_data_b, output_reg_val;
  logic       clear_busy, clear_done, wr_err;
  logic [7:0] rd_data_a6, rd_data_b6, output_reg_val6;
  logic       clear_busy6, clear_done6, wr_err6;

  int n_vec = 0;
  int n_bad = 0;

  multiport_register_file u_dut (
    .clock(clock), .reset_n(reset_n), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .rd_addr_a(rd_addr_a), .rd_addr_b(rd_addr_b), .rd_data_a(rd_data_a), .rd_data_b(rd_data_b),
    .clear_req(clear_req), .clear_busy(clear_busy), .clear_done(clear_done), .wr_err(wr_err),
    .output_reg_val(output_reg_val)
  );

  multiport_register_file #(.NUM_REGS(6)) u_dut6 (
    .clock(clock), .reset_n(reset_n), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .rd_addr_a(rd_addr_a), .rd_addr_b(rd_addr_b), .rd_data_a(rd_data_a6), .rd_data_b(rd_data_b6),
    .clear_req(clear_req), .clear_busy(clear_busy6), .clear_done(clear_done6), .wr_err(wr_err6),
    .output_reg_val(output_reg_val6)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic write(input logic [2:0] a, input logic [7:0] d);
    wr_en = 1'b1; wr_addr = a; wr_data = d;
    tick();
    wr_en = 1'b0;
  endtask

  int  busy_cycles;
  logic seen;

  initial begin
    reset_n = 1'b0; wr_en = 1'b0; clear_req = 1'b0;
    wr_addr = '0; wr_data = '0; rd_addr_a = '0; rd_addr_b = '0;
    #12;
    check("rst_rd_a", rd_data_a, 8'h00);
    check("rst_busy", clear_busy, 1'b0);
    check("rst_done", clear_done, 1'b0);
    check("rst_wr_err", wr_err, 1'b0);
    check("rst_out", output_reg_val, 8'h00);
    @(posedge clock);
    #3 reset_n = 1'b1;
    tick();

    // Dual read of the same register
    write(3'd3, 8'h5A);
    rd_addr_a = 3'd3; rd_addr_b = 3'd3; #1;
    check("rd_a_r3", rd_data_a, 8'h5A);
    check("rd_b_r3", rd_data_b, 8'h5A);
    check("rd_a6_r3", rd_data_a6, 8'h5A);

    // Address 6 is out of range only for the 6-entry instance
    rd_addr_a = 3'd6; rd_addr_b = 3'd7; #1;
    check("rd6_oor", rd_data_a6, 8'h00);
    check("rd6_oor7", rd_data_b6, 8'h00);
    wr_en = 1'b1; wr_addr = 3'd6; wr_data = 8'h77; #1;
    check("byp8_a6", rd_data_a, 8'h77);
    check("nobyp6_a6", rd_data_a6, 8'h00);
    tick();
    wr_en = 1'b0; #1;
    check("wr_err6_pulse", wr_err6, 1'b1);
    check("wr_err8_quiet", wr_err, 1'b0);
    check("rd8_r6", rd_data_a, 8'h77);
    tick();
    check("wr_err6_drop", wr_err6, 1'b0);

    // Write-first bypass, then stored
    wr_en = 1'b1; wr_addr = 3'd2; wr_data = 8'hC3; rd_addr_a = 3'd2; rd_addr_b = 3'd3; #1;
    check("byp_a_r2", rd_data_a, 8'hC3);
    check("rd_b_r3_diff", rd_data_b, 8'h5A);
    tick();
    wr_en = 1'b0; #1;
    check("stored_r2", rd_data_a, 8'hC3);

    // Fill and sweep
    for (int i = 0; i < 8; i++) write(3'(i), 8'(8'h11 * (i + 1)));
    check("out_filled", output_reg_val, 8'h88);
    clear_req = 1'b1;
    tick();
    clear_req = 1'b0;
    busy_cycles = 0;
    for (int i = 0; i < 20; i++) begin
      if (!clear_busy) break;
      busy_cycles++;
      if (busy_cycles == 4) begin
        rd_addr_a = 3'd5; rd_addr_b = 3'd1;
        wr_en = 1'b1; wr_addr = 3'd5; wr_data = 8'hEE; clear_req = 1'b1; #1;
        check("clr_rd_unswept", rd_data_a, 8'h66);
        check("clr_rd_swept", rd_data_b, 8'h00);
      end
      tick();
      wr_en = 1'b0; clear_req = 1'b0;
      if (busy_cycles == 4) check("clr_wr_err", wr_err, 1'b1);
    end
    check("busy_len", busy_cycles, 8);
    check("done_pulse", clear_done, 1'b1);
    clear_req = 1'b1;
    tick();
    clear_req = 1'b0;
    check("done_req_ignored", clear_busy, 1'b0);
    check("done_one_cycle", clear_done, 1'b0);
    for (int i = 0; i < 8; i++) begin
      rd_addr_a = 3'(i); #1;
      check("post_clr_rd", rd_data_a, 8'h00);
    end
    check("post_clr_out", output_reg_val, 8'h00);

    // Write and clear in the same IDLE cycle
    wr_en = 1'b1; wr_addr = 3'd7; wr_data = 8'hFF; clear_req = 1'b1;
    tick();
    wr_en = 1'b0; clear_req = 1'b0;
    for (int i = 0; i < 8; i++) begin
      check("out_hold_ff", output_reg_val, 8'hFF);
      tick();
    end
    check("out_cleared", output_reg_val, 8'h00);
    check("done_after_ff", clear_done, 1'b1);
    write(3'd4, 8'h99);
    rd_addr_a = 3'd4; #1;
    check("done_wr_ok_err", wr_err, 1'b0);
    check("done_wr_stored", rd_data_a, 8'h99);

    // Reset mid-sweep
    write(3'd7, 8'h42);
    clear_req = 1'b1;
    tick();
    clear_req = 1'b0;
    tick();
    tick();
    check("pre_rst_out", output_reg_val, 8'h42);
    check("pre_rst_busy", clear_busy, 1'b1);
    reset_n = 1'b0; #1;
    check("async_out", output_reg_val, 8'h00);
    check("async_busy", clear_busy, 1'b0);
    check("async_rd_r4", rd_data_a, 8'h00);
    @(posedge clock);
    #3 reset_n = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (clear_done || clear_busy) seen = 1'b1;
    end
    check("no_done_after_rst", seen, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
